pong_sequencer: RTL and testbench

PONG_SEQUENCER -- requirements
Module: pong_sequencer

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_sequencer_if.sv | 39 +++
 rtl/bcd_score_counter.sv | 30 +++
 rtl/pong_sequencer.sv | 158 +++++++++++++++
 tb/tb_pong_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong game sequencer.
// PONG_PAUSE_EN adds the PAUSED state encoding.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_MISS      = 3'd3,
        ST_GAME_OVER = 3'd4
`ifdef PONG_PAUSE_EN
        ,
        ST_PAUSED    = 3'd5
`endif
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned DEF_SERVE_FRAMES   = 60;
    localparam int unsigned DEF_MISS_FRAMES    = 30;
    localparam int unsigned DEF_HITS_PER_LEVEL = 5;
    localparam int unsigned DEF_START_LIVES    = 3;

    localparam logic [2:0] SPEED_MIN = 3'd1;
    localparam logic [2:0] SPEED_MAX = 3'd7;

    function automatic bcd_digit_t bcd_digit_inc(input bcd_digit_t d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/pong_sequencer_if.sv
// Control/status bundle between the pong datapath and the sequencer.
// PONG_PAUSE_EN adds the pause request pulse.
interface pong_sequencer_if;
    import pong_pkg::*;

    logic       frame_tick;
    logic       start;
    logic       paddle_hit;
    logic       ball_miss;
`ifdef PONG_PAUSE_EN
    logic       pause;
`endif
    logic       ball_enable;
    logic       ball_reset;
    logic [2:0] speed;
    logic [1:0] lives;
    logic [7:0] score;
    logic       flash;
    state_t     state;

    modport master (
`ifdef PONG_PAUSE_EN
        output pause,
`endif
        output frame_tick, start, paddle_hit, ball_miss,
        input  ball_enable, ball_reset, speed, lives,
        input  score, flash, state
    );

    modport slave (
`ifdef PONG_PAUSE_EN
        input  pause,
`endif
        input  frame_tick, start, paddle_hit, ball_miss,
        output ball_enable, ball_reset, speed, lives,
        output score, flash, state
    );

endinterface

// File: rtl/bcd_score_counter.sv
// Two-digit BCD hit counter, wraps 99 -> 00.
// Clear has priority over increment.
module bcd_score_counter
    import pong_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       clear,
    input  logic       inc,
    output logic [7:0] score
);

    bcd_digit_t tens;
    bcd_digit_t units;

    // Units roll into tens; tens rolls back to zero after 9.
    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            tens  <= 4'd0;
            units <= 4'd0;
        end else if (inc) begin
            units <= bcd_digit_inc(units);
            if (units == 4'd9)
                tens <= bcd_digit_inc(tens);
        end
    end

    assign score = {tens, units};

endmodule

// File: rtl/pong_sequencer.sv
// Pong game-flow FSM: serve, play, miss, game over.
// PONG_PAUSE_EN adds the pause input and PAUSED state.
module pong_sequencer
    import pong_pkg::*;
#(
    parameter int unsigned SERVE_FRAMES   = DEF_SERVE_FRAMES,
    parameter int unsigned MISS_FRAMES    = DEF_MISS_FRAMES,
    parameter int unsigned HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
    parameter int unsigned START_LIVES    = DEF_START_LIVES
) (
    input logic              Clock,
    input logic              Reset,
    pong_sequencer_if.slave  bus
);

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);
    localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_LEVEL - 1);
    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] frame_cnt;
    logic [3:0] hit_cnt;
    logic [2:0] speed_q;
    logic [1:0] lives_q;
    logic       enable_q;
    logic       pause_in;
    logic       start_ok;
    logic       hit_ok;
    logic       miss_ok;

`ifdef PONG_PAUSE_EN
    assign pause_in = bus.pause;
`else
    assign pause_in = 1'b0;
`endif

    // State register; reset overrides every input that cycle.
    always_ff @(posedge Clock) begin
        if (Reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state plus the accepted-event strobes for the datapath.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        hit_ok   = 1'b0;
        miss_ok  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (bus.start) begin
                    start_ok = 1'b1;
                    state_d  = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (bus.frame_tick && frame_cnt == SERVE_LAST)
                    state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.ball_miss) begin
                    miss_ok = 1'b1;
                    state_d = ST_MISS;
                end else begin
                    hit_ok = bus.paddle_hit;
`ifdef PONG_PAUSE_EN
                    if (pause_in)
                        state_d = ST_PAUSED;
`endif
                end
            end
            ST_MISS: begin
                if (bus.frame_tick && frame_cnt == MISS_LAST)
                    state_d = (lives_q == 2'd0) ? ST_GAME_OVER
                                                : ST_SERVE;
            end
`ifdef PONG_PAUSE_EN
            ST_PAUSED: begin
                if (pause_in)
                    state_d = ST_PLAY;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame counter restarts on every state change; counts only in
    // the timed states, so it stays frozen while paused.
    always_ff @(posedge Clock) begin
        if (Reset)
            frame_cnt <= 8'd0;
        else if (state_d != state_q)
            frame_cnt <= 8'd0;
        else if (bus.frame_tick &&
                 (state_q == ST_SERVE || state_q == ST_MISS))
            frame_cnt <= frame_cnt + 8'd1;
    end

    // Lives: loaded on start, one lost per accepted miss.
    always_ff @(posedge Clock) begin
        if (Reset)
            lives_q <= 2'd0;
        else if (start_ok)
            lives_q <= LIVES_INIT;
        else if (miss_ok && lives_q != 2'd0)
            lives_q <= lives_q - 2'd1;
    end

    // Speed level: one step per HITS_PER_LEVEL hits, saturating.
    always_ff @(posedge Clock) begin
        if (Reset || start_ok) begin
            speed_q <= SPEED_MIN;
            hit_cnt <= 4'd0;
        end else if (hit_ok) begin
            if (hit_cnt == HIT_LAST) begin
                hit_cnt <= 4'd0;
                if (speed_q != SPEED_MAX)
                    speed_q <= speed_q + 3'd1;
            end else begin
                hit_cnt <= hit_cnt + 4'd1;
            end
        end
    end

    // One ball update per frame, one cycle after the tick, unless
    // the same cycle loses the ball or pauses the game.
    always_ff @(posedge Clock) begin
        if (Reset)
            enable_q <= 1'b0;
        else
            enable_q <= (state_q == ST_PLAY) && bus.frame_tick &&
                        !bus.ball_miss && !pause_in;
    end

    bcd_score_counter u_score (
        .Clock (Clock),
        .Reset (Reset),
        .clear (start_ok),
        .inc   (hit_ok),
        .score (bus.score)
    );

    assign bus.ball_enable = enable_q;
    assign bus.ball_reset  = (state_q == ST_IDLE)  ||
                             (state_q == ST_SERVE) ||
                             (state_q == ST_GAME_OVER);
    assign bus.speed       = speed_q;
    assign bus.lives       = lives_q;
    // Frame count bit 3 flips every 8 ticks, so MISS starts lit.
    assign bus.flash       = (state_q == ST_MISS) ? ~frame_cnt[3]
                                                  : (state_q == ST_GAME_OVER);
    assign bus.state       = state_q;

endmodule

// File: tb/tb_pong_sequencer.sv
// Directed testbench for pong_sequencer.
module tb_pong_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pong_sequencer_if bus ();

    pong_sequencer dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            cyc();
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            bus.paddle_hit = 1'b1;
            cyc();
            bus.paddle_hit = 1'b0;
        end
    endtask

    task automatic miss();
        bus.ball_miss = 1'b1;
        cyc();
        bus.ball_miss = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", bus.state); end
        checks++; if (bus.ball_enable !== 1'b0) begin errors++; $display("FAIL rst_en got %0b want 0", bus.ball_enable); end
        checks++; if (bus.ball_reset !== 1'b1) begin errors++; $display("FAIL rst_breset got %0b want 1", bus.ball_reset); end
        checks++; if (bus.speed !== 3'd1) begin errors++; $display("FAIL rst_speed got %0d want 1", bus.speed); end
        checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL rst_lives got %0d want 0", bus.lives); end
        checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL rst_score got %h want 00", bus.score); end
        checks++; if (bus.flash !== 1'b0) begin errors++; $display("FAIL rst_flash got %0b want 0", bus.flash); end
        rst = 1'b0;
        hits(1);
        miss();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL idle_ignore_state got %0d want 0", bus.state); end
        checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL idle_ignore_score got %h want 00", bus.score); end
    endtask

    task automatic test_serve();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL serve_state got %0d want 1", bus.state); end
        checks++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL serve_lives got %0d want 3", bus.lives); end
        checks++; if (bus.ball_reset !== 1'b1) begin errors++; $display("FAIL serve_breset got %0b want 1", bus.ball_reset); end
        ticks(59);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL serve_59_state got %0d want 1", bus.state); end
        ticks(1);
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL serve_60_state got %0d want 2", bus.state); end
        checks++; if (bus.ball_reset !== 1'b0) begin errors++; $display("FAIL play_breset got %0b want 0", bus.ball_reset); end
        checks++; if (bus.ball_enable !== 1'b0) begin errors++; $display("FAIL serve_tick_en got %0b want 0", bus.ball_enable); end
        checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL play_score got %h want 00", bus.score); end
        checks++; if (bus.speed !== 3'd1) begin errors++; $display("FAIL play_speed got %0d want 1", bus.speed); end
    endtask

    task automatic test_ball_enable();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        checks++; if (bus.ball_enable !== 1'b1) begin errors++; $display("FAIL en_n1 got %0b want 1", bus.ball_enable); end
        cyc();
        checks++; if (bus.ball_enable !== 1'b0) begin errors++; $display("FAIL en_n2 got %0b want 0", bus.ball_enable); end
    endtask

    task automatic test_hits();
        hits(5);
        checks++; if (bus.score !== 8'h05) begin errors++; $display("FAIL hit5_score got %h want 05", bus.score); end
        checks++; if (bus.speed !== 3'd2) begin errors++; $display("FAIL hit5_speed got %0d want 2", bus.speed); end
        hits(5);
        checks++; if (bus.score !== 8'h10) begin errors++; $display("FAIL hit10_score got %h want 10", bus.score); end
        hits(89);
        checks++; if (bus.score !== 8'h99) begin errors++; $display("FAIL hit99_score got %h want 99", bus.score); end
        checks++; if (bus.speed !== 3'd7) begin errors++; $display("FAIL hit99_speed got %0d want 7", bus.speed); end
        hits(1);
        checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL hit100_score got %h want 00", bus.score); end
        checks++; if (bus.speed !== 3'd7) begin errors++; $display("FAIL hit100_speed got %0d want 7", bus.speed); end
    endtask

    task automatic test_hit_miss();
        bus.frame_tick = 1'b1;
        bus.paddle_hit = 1'b1;
        bus.ball_miss  = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        bus.paddle_hit = 1'b0;
        bus.ball_miss  = 1'b0;
        checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL hm_score got %h want 00", bus.score); end
        checks++; if (bus.lives !== 2'd2) begin errors++; $display("FAIL hm_lives got %0d want 2", bus.lives); end
        checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL hm_state got %0d want 3", bus.state); end
        checks++; if (bus.ball_enable !== 1'b0) begin errors++; $display("FAIL hm_en got %0b want 0", bus.ball_enable); end
        checks++; if (bus.ball_reset !== 1'b0) begin errors++; $display("FAIL miss_breset got %0b want 0", bus.ball_reset); end
    endtask

    task automatic test_miss_flash();
        ticks(7);
        checks++; if (bus.flash !== 1'b1) begin errors++; $display("FAIL flash_t7 got %0b want 1", bus.flash); end
        ticks(1);
        checks++; if (bus.flash !== 1'b0) begin errors++; $display("FAIL flash_t8 got %0b want 0", bus.flash); end
        ticks(8);
        checks++; if (bus.flash !== 1'b1) begin errors++; $display("FAIL flash_t16 got %0b want 1", bus.flash); end
        ticks(8);
        checks++; if (bus.flash !== 1'b0) begin errors++; $display("FAIL flash_t24 got %0b want 0", bus.flash); end
        ticks(5);
        checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL miss_t29 got %0d want 3", bus.state); end
        ticks(1);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL miss_t30 got %0d want 1", bus.state); end
        checks++; if (bus.speed !== 3'd7) begin errors++; $display("FAIL miss_speed got %0d want 7", bus.speed); end
        checks++; if (bus.flash !== 1'b0) begin errors++; $display("FAIL serve_flash got %0b want 0", bus.flash); end
        ticks(60);
    endtask

    task automatic test_game_over();
        hits(3);
        checks++; if (bus.score !== 8'h03) begin errors++; $display("FAIL go_hits got %h want 03", bus.score); end
        miss();
        ticks(30);
        checks++; if (bus.lives !== 2'd1) begin errors++; $display("FAIL go_lives1 got %0d want 1", bus.lives); end
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL go_serve2 got %0d want 1", bus.state); end
        ticks(60);
        miss();
        checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL go_lives0 got %0d want 0", bus.lives); end
        ticks(30);
        checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL go_state got %0d want 4", bus.state); end
        checks++; if (bus.flash !== 1'b1) begin errors++; $display("FAIL go_flash got %0b want 1", bus.flash); end
        checks++; if (bus.ball_reset !== 1'b1) begin errors++; $display("FAIL go_breset got %0b want 1", bus.ball_reset); end
        hits(2);
        checks++; if (bus.score !== 8'h03) begin errors++; $display("FAIL go_score got %h want 03", bus.score); end
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL restart_state got %0d want 1", bus.state); end
        checks++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL restart_lives got %0d want 3", bus.lives); end
        checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL restart_score got %h want 00", bus.score); end
        checks++; if (bus.speed !== 3'd1) begin errors++; $display("FAIL restart_speed got %0d want 1", bus.speed); end
    endtask

    task automatic test_reset_mid();
        ticks(60);
        hits(2);
        miss();
        ticks(3);
        checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL mid_pre got %0d want 3", bus.state); end
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.frame_tick = 1'b1;
        bus.paddle_hit = 1'b1;
        cyc();
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.frame_tick = 1'b0;
        bus.paddle_hit = 1'b0;
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL mid_state got %0d want 0", bus.state); end
        checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL mid_lives got %0d want 0", bus.lives); end
        checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL mid_score got %h want 00", bus.score); end
        checks++; if (bus.flash !== 1'b0) begin errors++; $display("FAIL mid_flash got %0b want 0", bus.flash); end
        checks++; if (bus.ball_reset !== 1'b1) begin errors++; $display("FAIL mid_breset got %0b want 1", bus.ball_reset); end
        checks++; if (bus.speed !== 3'd1) begin errors++; $display("FAIL mid_speed got %0d want 1", bus.speed); end
        checks++; if (bus.ball_enable !== 1'b0) begin errors++; $display("FAIL mid_en got %0b want 0", bus.ball_enable); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.paddle_hit = 1'b0;
        bus.ball_miss  = 1'b0;
`ifdef PONG_PAUSE_EN
        bus.pause      = 1'b0;
`endif
        test_reset();
        test_serve();
        test_ball_enable();
        test_hits();
        test_hit_miss();
        test_miss_flash();
        test_game_over();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
